// File: rtl/audio_mix_seq.sv
// audio_mix_seq: N-channel sequential audio mixer.
// Once per sample tick every channel is snapshotted together with its gain and
// mute setting, then the channels are scaled and summed one per clock. The sum
// is clamped to the output range and presented as an offset-binary sample.
// Gain, mute and channel select are programmed through three I/O ports.
module audio_mix_seq #(
  parameter int         NCH       = 4,
  parameter int         IW        = 16,
  parameter int         GW        = 4,
  parameter logic [7:0] CH_SIGNED = 8'b0000_0000,
  parameter int         SMP_DIV   = 608,
  parameter logic [7:0] IO_BASE   = 8'h48
) (
  input  logic              ex_clk_27m,
  input  logic              reset_n,
  input  logic [7:0]        io_addr,
  input  logic [7:0]        io_data,
  input  logic              io_wr_n,
  input  logic [NCH*IW-1:0] ch_data,
  output logic [IW-1:0]     out_sample,
  output logic              out_valid,
  output logic              clip,
  output logic              busy
);

  localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int DW   = (SMP_DIV > 1) ? $clog2(SMP_DIV) : 1;
  // Accumulator is wide enough that NCH full-scale terms at maximum gain never wrap.
  localparam int AW   = IW + GW + $clog2(NCH) + 1;
  // Product of an (IW+1)-bit sample and a (GW+1)-bit non-negative gain.
  localparam int PW   = IW + GW + 2;

  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-IW+1){1'b0}}, {(IW-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-IW+1){1'b1}}, {(IW-1){1'b0}}};
  localparam logic [GW-1:0]        GAIN_UNITY = {1'b1, {(GW-1){1'b0}}};
  localparam logic [IW-1:0]        OUT_MID    = {1'b1, {(IW-1){1'b0}}};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LATCH = 3'd1,
    ST_ACC   = 3'd2,
    ST_SAT   = 3'd3,
    ST_OUT   = 3'd4
  } state_t;

  // Offset binary and two's complement differ only in the MSB.
  function automatic logic [IW-1:0] to_offset(input logic [IW-1:0] v);
    return {~v[IW-1], v[IW-2:0]};
  endfunction

  // ---------------------------------------------------------------------------
  // I/O bus decode
  // ---------------------------------------------------------------------------
  logic           wr_prev_r;
  logic           wr_fall_s;
  logic           sel_wr_s;
  logic           gain_wr_s;
  logic           clr_wr_s;
  logic           sel_ok_s;
  logic [2:0]     select_r;
  logic [GW-1:0]  gain_r [NCH];
  logic [NCH-1:0] mute_r;
  logic           unused_io_s;

  // A write is taken only on the clock that sees io_wr_n go from 1 to 0,
  // so a strobe held low for several clocks counts once.
  assign wr_fall_s   = wr_prev_r & ~io_wr_n;
  assign sel_wr_s    = wr_fall_s & (io_addr == IO_BASE);
  assign gain_wr_s   = wr_fall_s & (io_addr == (IO_BASE + 8'd1));
  assign clr_wr_s    = wr_fall_s & (io_addr == (IO_BASE + 8'd2));
  assign sel_ok_s    = ({1'b0, select_r} < 4'(NCH));
  assign unused_io_s = ^io_data;

  // Previous write-strobe level for falling-edge detection.
  always_ff @(posedge ex_clk_27m or negedge reset_n) begin
    if (!reset_n) begin
      wr_prev_r <= 1'b1;
    end else begin
      wr_prev_r <= io_wr_n;
    end
  end

  // Channel select register.
  always_ff @(posedge ex_clk_27m or negedge reset_n) begin
    if (!reset_n) begin
      select_r <= 3'd0;
    end else if (sel_wr_s) begin
      select_r <= io_data[2:0];
    end
  end

  // Live gain/mute registers; a select beyond the last channel drops the write.
  always_ff @(posedge ex_clk_27m or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NCH; k++) begin
        gain_r[k] <= GAIN_UNITY;
      end
      mute_r <= {NCH{1'b0}};
    end else if (gain_wr_s && sel_ok_s) begin
      gain_r[select_r[IDXW-1:0]] <= io_data[GW-1:0];
      mute_r[select_r[IDXW-1:0]] <= io_data[7];
    end
  end

  // ---------------------------------------------------------------------------
  // Sample-rate divider
  // ---------------------------------------------------------------------------
  logic [DW-1:0] div_cnt_r;
  logic          tick_s;

  assign tick_s = (div_cnt_r == DW'(SMP_DIV - 1));

  // Free-running divider; keeps counting whatever the sequencer is doing.
  always_ff @(posedge ex_clk_27m or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_r <= {DW{1'b0}};
    end else if (tick_s) begin
      div_cnt_r <= {DW{1'b0}};
    end else begin
      div_cnt_r <= div_cnt_r + DW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  state_t          state_r;
  state_t          state_nxt_s;
  logic [IDXW-1:0] idx_r;
  logic            last_ch_s;

  assign last_ch_s = (idx_r == IDXW'(NCH - 1));

  // State register.
  always_ff @(posedge ex_clk_27m or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: one frame is LATCH, NCH ACC cycles, SAT, OUT.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (tick_s) begin
          state_nxt_s = ST_LATCH;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LATCH: state_nxt_s = ST_ACC;
      ST_ACC: begin
        if (last_ch_s) begin
          state_nxt_s = ST_SAT;
        end else begin
          state_nxt_s = ST_ACC;
        end
      end
      ST_SAT:  state_nxt_s = ST_OUT;
      ST_OUT:  state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  logic [IW-1:0]         snap_ch_r   [NCH];
  logic [GW-1:0]         snap_gain_r [NCH];
  logic [NCH-1:0]        snap_mute_r;
  logic signed [AW-1:0]  acc_r;
  logic [IW-1:0]         cur_ch_s;
  logic signed [IW:0]    cur_s_s;
  logic signed [PW-1:0]  prod_s;
  logic signed [PW-1:0]  scaled_s;
  logic signed [AW-1:0]  term_s;
  logic [IW-1:0]         clamp_s;
  logic                  sat_s;

  // Scale the current channel: convert to signed, multiply by gain, drop the
  // unity-gain fraction bits with an arithmetic shift, zero it when muted.
  always_comb begin
    cur_ch_s = snap_ch_r[idx_r];
    if (CH_SIGNED[idx_r]) begin
      cur_s_s = {cur_ch_s[IW-1], cur_ch_s};
    end else begin
      cur_s_s = {~cur_ch_s[IW-1], ~cur_ch_s[IW-1], cur_ch_s[IW-2:0]};
    end
    prod_s   = PW'(cur_s_s) * PW'($signed({1'b0, snap_gain_r[idx_r]}));
    scaled_s = prod_s >>> (GW - 1);
    if (snap_mute_r[idx_r]) begin
      term_s = {AW{1'b0}};
    end else begin
      term_s = AW'(scaled_s);
    end
  end

  // Clamp the finished sum to the signed IW-bit range.
  always_comb begin
    if (acc_r > SAT_MAX) begin
      clamp_s = SAT_MAX[IW-1:0];
      sat_s   = 1'b1;
    end else if (acc_r < SAT_MIN) begin
      clamp_s = SAT_MIN[IW-1:0];
      sat_s   = 1'b1;
    end else begin
      clamp_s = acc_r[IW-1:0];
      sat_s   = 1'b0;
    end
  end

  // Frame snapshot and sequential accumulation. Gains are copied here so a
  // write landing mid-frame only takes effect on the following frame.
  always_ff @(posedge ex_clk_27m or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NCH; k++) begin
        snap_ch_r[k]   <= {IW{1'b0}};
        snap_gain_r[k] <= GAIN_UNITY;
      end
      snap_mute_r <= {NCH{1'b0}};
      acc_r       <= {AW{1'b0}};
      idx_r       <= {IDXW{1'b0}};
    end else begin
      case (state_r)
        ST_LATCH: begin
          for (int k = 0; k < NCH; k++) begin
            snap_ch_r[k]   <= ch_data[k*IW +: IW];
            snap_gain_r[k] <= gain_r[k];
          end
          snap_mute_r <= mute_r;
          acc_r       <= {AW{1'b0}};
          idx_r       <= {IDXW{1'b0}};
        end
        ST_ACC: begin
          acc_r <= acc_r + term_s;
          idx_r <= idx_r + IDXW'(1);
        end
        default: begin
          acc_r <= acc_r;
          idx_r <= idx_r;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  logic [IW-1:0] out_sample_r;
  logic          out_valid_r;
  logic          clip_r;
  logic          busy_r;
  logic          sat_hit_s;

  assign sat_hit_s = (state_r == ST_SAT) & sat_s;

  // Registered outputs: sample and valid pulse appear in the OUT cycle, clip is
  // sticky with set beating a simultaneous clear, busy spans LATCH..OUT.
  always_ff @(posedge ex_clk_27m or negedge reset_n) begin
    if (!reset_n) begin
      out_sample_r <= OUT_MID;
      out_valid_r  <= 1'b0;
      clip_r       <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      out_valid_r <= (state_r == ST_SAT);
      busy_r      <= (state_nxt_s != ST_IDLE);
      if (state_r == ST_SAT) begin
        out_sample_r <= to_offset(clamp_s);
      end
      if (sat_hit_s) begin
        clip_r <= 1'b1;
      end else if (clr_wr_s) begin
        clip_r <= 1'b0;
      end
    end
  end

  assign out_sample = out_sample_r;
  assign out_valid  = out_valid_r;
  assign clip       = clip_r;
  assign busy       = busy_r;

endmodule
